// File: rtl/pbvi_step_ctrl.sv
// Episode sequencer for the PBVI POMDP agent: owns the belief register and walks
// decide -> emit action -> take observation -> update belief, HORIZON times per episode.
module pbvi_step_ctrl #(
  parameter int HORIZON = 16,
  parameter int TIMEOUT = 64,
  parameter int BW      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2*BW-1:0] init_belief,
  output logic            dec_start,
  output logic [2*BW-1:0] dec_belief,
  input  logic            dec_done,
  input  logic [1:0]      dec_action,
  output logic            act_valid,
  input  logic            act_ready,
  output logic [1:0]      act,
  output logic            obs_ready,
  input  logic            obs_valid,
  input  logic            obs,
  output logic            upd_start,
  output logic [1:0]      upd_action,
  output logic            upd_obs,
  output logic [2*BW-1:0] upd_belief,
  input  logic            upd_done,
  input  logic [2*BW-1:0] upd_result,
  output logic [2*BW-1:0] belief,
  output logic [15:0]     step_cnt,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            degen
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]   HLAST = 16'(HORIZON);

  typedef enum logic [3:0] {
    IDLE, DEC_GO, DEC_WAIT, EMIT, OBS, UPD_GO, UPD_WAIT, NEXT, DONE, ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [2*BW-1:0] belief_q;
  logic [15:0]     step_q;
  logic [1:0]      act_q;
  logic            obs_q;
  logic            degen_q;
  logic            waiting;
  logic            idle_like;

  assign waiting   = (state == DEC_WAIT) || (state == UPD_WAIT);
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = DEC_GO;
      DEC_GO:            state_nxt = DEC_WAIT;
      DEC_WAIT: begin
        if (dec_done)            state_nxt = EMIT;
        else if (timer == TLAST) state_nxt = ERROR;
      end
      EMIT:              if (act_ready) state_nxt = OBS;
      OBS:               if (obs_valid) state_nxt = UPD_GO;
      UPD_GO:            state_nxt = UPD_WAIT;
      UPD_WAIT: begin
        if (upd_done)            state_nxt = NEXT;
        else if (timer == TLAST) state_nxt = ERROR;
      end
      NEXT:              state_nxt = (step_q == HLAST) ? DONE : DEC_GO;
      default:           state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      belief_q <= '0;
      step_q   <= '0;
      act_q    <= '0;
      obs_q    <= 1'b0;
      degen_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Timer restarts whenever a wait state is entered or left.
      timer <= (waiting && state_nxt == state) ? timer + TW'(1) : '0;
      if (abort) begin
        degen_q <= 1'b0;
      end else begin
        if (idle_like && start) begin
          belief_q <= init_belief;
          step_q   <= '0;
          degen_q  <= 1'b0;
        end
        if (state == DEC_WAIT && dec_done) act_q <= dec_action;
        if (state == OBS && obs_valid)     obs_q <= obs;
        if (state == UPD_WAIT && upd_done) begin
          step_q <= step_q + 16'd1;
          // An all-zero belief is meaningless; keep the old one and flag it.
          if (upd_result == '0) degen_q  <= 1'b1;
          else                  belief_q <= upd_result;
        end
      end
    end
  end

  assign dec_start  = (state == DEC_GO);
  assign act_valid  = (state == EMIT);
  assign obs_ready  = (state == OBS);
  assign upd_start  = (state == UPD_GO);
  assign busy       = !idle_like;
  assign done       = (state == DONE);
  assign err        = (state == ERROR);
  assign dec_belief = belief_q;
  assign upd_belief = belief_q;
  assign belief     = belief_q;
  assign act        = act_q;
  assign upd_action = act_q;
  assign upd_obs    = obs_q;
  assign step_cnt   = step_q;
  assign degen      = degen_q;

endmodule
